// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared ALU constants for the adder bit slice
`timescale 1ps/1ps

package full_adder_pkg;

  // Propagation delay of one gate primitive, in ps.
  localparam int GATE_DELAY_PS = 50;

  // Width of the ripple-carry adder built from full_adder slices.
  localparam int ADDER_WIDTH = 64;

endpackage

// File: rtl/full_adder_half_adder.sv
// rtl/full_adder_half_adder.sv - gate-level half adder (xor + and)
`timescale 1ps/1ps

module half_adder
  import full_adder_pkg::*;
#(
  parameter int GATE_DELAY = GATE_DELAY_PS
) (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  xor #(GATE_DELAY) u_xor (s, a, b);
  and #(GATE_DELAY) u_and (c, a, b);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder slice with optional output register
`timescale 1ps/1ps

module full_adder
  import full_adder_pkg::*;
#(
  parameter bit REGISTERED = 1'b0,
  parameter int GATE_DELAY = GATE_DELAY_PS,
  parameter bit EXPOSE_PG  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout,
  output logic p,
  output logic g
);

  logic x1;
  logic g_int;
  logic sum_c;
  logic t;
  logic cout_c;

  // First half adder's xor/and are the slice's propagate/generate terms.
  half_adder #(.GATE_DELAY(GATE_DELAY)) u_ha0 (
    .a (a),
    .b (b),
    .s (x1),
    .c (g_int)
  );

  half_adder #(.GATE_DELAY(GATE_DELAY)) u_ha1 (
    .a (x1),
    .b (cin),
    .s (sum_c),
    .c (t)
  );

  or #(GATE_DELAY) u_or (cout_c, g_int, t);

  generate
    if (REGISTERED) begin : g_reg
      logic sum_q;
      logic cout_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          sum_q  <= 1'b0;
          cout_q <= 1'b0;
        end else begin
          sum_q  <= sum_c;
          cout_q <= cout_c;
        end
      end

      assign sum  = sum_q;
      assign cout = cout_q;
    end else begin : g_comb
      // clk and reset have no function in the combinational slice.
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;

      assign sum  = sum_c;
      assign cout = cout_c;
    end

    if (EXPOSE_PG) begin : g_pg
      assign p = x1;
      assign g = g_int;
    end else begin : g_no_pg
      assign p = 1'b0;
      assign g = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder
`timescale 1ps/1ps

module tb_full_adder;
  import full_adder_pkg::*;

  int n_cmp = 0;
  int n_bad = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5000 clk = ~clk;

  // Combinational slice.
  logic ca = 1'b0, cb = 1'b0, cc = 1'b0;
  logic c_sum, c_cout, c_p, c_g;

  full_adder #(.REGISTERED(1'b0)) u_comb (
    .clk (clk), .reset (reset), .a (ca), .b (cb), .cin (cc),
    .sum (c_sum), .cout (c_cout), .p (c_p), .g (c_g)
  );

  // Same inputs, p/g suppressed.
  logic n_sum, n_cout, n_p, n_g;

  full_adder #(.REGISTERED(1'b0), .EXPOSE_PG(1'b0)) u_nopg (
    .clk (clk), .reset (reset), .a (ca), .b (cb), .cin (cc),
    .sum (n_sum), .cout (n_cout), .p (n_p), .g (n_g)
  );

  // Registered slice.
  logic ra = 1'b0, rb = 1'b0, rc = 1'b0;
  logic r_sum, r_cout, r_p, r_g;

  full_adder #(.REGISTERED(1'b1)) u_reg (
    .clk (clk), .reset (reset), .a (ra), .b (rb), .cin (rc),
    .sum (r_sum), .cout (r_cout), .p (r_p), .g (r_g)
  );

  // 64-slice ripple chain.
  logic [ADDER_WIDTH-1:0] ch_a = '0, ch_b = '0;
  logic ch_cin = 1'b0;
  wire  [ADDER_WIDTH:0]   ch_c;
  wire  [ADDER_WIDTH-1:0] ch_s, ch_p, ch_g;

  assign ch_c[0] = ch_cin;

  genvar gi;
  generate
    for (gi = 0; gi < ADDER_WIDTH; gi++) begin : g_chain
      full_adder u_fa (
        .clk (clk), .reset (reset), .a (ch_a[gi]), .b (ch_b[gi]), .cin (ch_c[gi]),
        .sum (ch_s[gi]), .cout (ch_c[gi+1]), .p (ch_p[gi]), .g (ch_g[gi])
      );
    end
  endgenerate

  task automatic test_truth_table();
    logic [7:0] exp_s = 8'h96;
    logic [7:0] exp_c = 8'hE8;
    logic [7:0] exp_p = 8'h3C;
    logic [7:0] exp_g = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      {ca, cb, cc} = i[2:0];
      #200;
      n_cmp++;
      if (c_sum !== exp_s[i] || c_cout !== exp_c[i]) begin
        n_bad++;
        $display("FAIL truth_%0d%0d%0d: got sum=%b cout=%b, want sum=%b cout=%b",
                 ca, cb, cc, c_sum, c_cout, exp_s[i], exp_c[i]);
      end
      n_cmp++;
      if (c_p !== exp_p[i] || c_g !== exp_g[i]) begin
        n_bad++;
        $display("FAIL pg_%0d%0d%0d: got p=%b g=%b, want p=%b g=%b",
                 ca, cb, cc, c_p, c_g, exp_p[i], exp_g[i]);
      end
      n_cmp++;
      if (n_p !== 1'b0 || n_g !== 1'b0 || n_sum !== exp_s[i] || n_cout !== exp_c[i]) begin
        n_bad++;
        $display("FAIL nopg_%0d%0d%0d: got p=%b g=%b sum=%b cout=%b, want p=0 g=0 sum=%b cout=%b",
                 ca, cb, cc, n_p, n_g, n_sum, n_cout, exp_s[i], exp_c[i]);
      end
    end
  endtask

  task automatic test_timing();
    // 000 -> 101: sum settles after xor->xor, cout after xor->and->or.
    {ca, cb, cc} = 3'b000;
    #500;
    {ca, cb, cc} = 3'b101;
    #99;
    n_cmp++;
    if (c_sum === 1'b0 && c_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL timing_early_99: got sum=%b cout=%b, want sum not yet 0, cout=0", c_sum, c_cout);
    end else if (c_sum === 1'b0) begin
      n_bad++;
      $display("FAIL timing_sum_early: got sum=%b at +99ps, want not 0 yet", c_sum);
    end
    #2;
    n_cmp++;
    if (c_sum !== 1'b0 || c_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL timing_101: got sum=%b cout=%b, want sum=0 cout=0", c_sum, c_cout);
    end
    #48;
    n_cmp++;
    if (c_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL timing_cout_149: got cout=%b, want 0", c_cout);
    end
    #2;
    n_cmp++;
    if (c_cout !== 1'b1 || c_sum !== 1'b0) begin
      n_bad++;
      $display("FAIL timing_cout_151: got sum=%b cout=%b, want sum=0 cout=1", c_sum, c_cout);
    end
    // Generate path: 000 -> 110.
    {ca, cb, cc} = 3'b000;
    #500;
    {ca, cb, cc} = 3'b110;
    #99;
    n_cmp++;
    if (c_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL timing_g_99: got cout=%b, want 0", c_cout);
    end
    #2;
    n_cmp++;
    if (c_cout !== 1'b1) begin
      n_bad++;
      $display("FAIL timing_g_101: got cout=%b, want 1", c_cout);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    {ra, rb, rc} = 3'b111;
    repeat (2) @(posedge clk);
    #1000;
    n_cmp++;
    if (r_sum !== 1'b0 || r_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got sum=%b cout=%b, want 0 0", r_sum, r_cout);
    end
    @(negedge clk);
    reset = 1'b0;
    #1000;
    n_cmp++;
    if (r_sum !== 1'b0 || r_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_pre_edge: got sum=%b cout=%b, want 0 0", r_sum, r_cout);
    end
    @(posedge clk);
    #1000;
    n_cmp++;
    if (r_sum !== 1'b1 || r_cout !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_first_capture: got sum=%b cout=%b, want 1 1", r_sum, r_cout);
    end
  endtask

  task automatic test_pipeline();
    @(negedge clk);
    {ra, rb, rc} = 3'b101;
    #1000;
    n_cmp++;
    if (r_sum !== 1'b1 || r_cout !== 1'b1) begin
      n_bad++;
      $display("FAIL pipe_hold: got sum=%b cout=%b, want 1 1", r_sum, r_cout);
    end
    n_cmp++;
    if (r_p !== 1'b1 || r_g !== 1'b0) begin
      n_bad++;
      $display("FAIL pipe_pg_comb: got p=%b g=%b, want p=1 g=0", r_p, r_g);
    end
    @(posedge clk);
    #1000;
    n_cmp++;
    if (r_sum !== 1'b0 || r_cout !== 1'b1) begin
      n_bad++;
      $display("FAIL pipe_capture: got sum=%b cout=%b, want 0 1", r_sum, r_cout);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1000;
    n_cmp++;
    if (r_sum !== 1'b0 || r_cout !== 1'b0) begin
      n_bad++;
      $display("FAIL pipe_reset: got sum=%b cout=%b, want 0 0", r_sum, r_cout);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chain_case(input string name, input logic [63:0] a_v, input logic [63:0] b_v,
                            input logic cin_v, input logic [63:0] exp_s, input logic exp_co,
                            input logic exp_of);
    ch_a = a_v;
    ch_b = b_v;
    ch_cin = cin_v;
    #20000;
    n_cmp++;
    if (ch_s !== exp_s || ch_c[64] !== exp_co || (ch_c[63] ^ ch_c[64]) !== exp_of) begin
      n_bad++;
      $display("FAIL chain_%s: got s=%h co=%b of=%b, want s=%h co=%b of=%b",
               name, ch_s, ch_c[64], ch_c[63] ^ ch_c[64], exp_s, exp_co, exp_of);
    end
  endtask

  task automatic test_chain();
    chain_case("256p100", 64'd256, 64'd100, 1'b0, 64'd356, 1'b0, 1'b0);
    chain_case("20m_m5", 64'd20, ~(-64'sd5), 1'b1, 64'd25, 1'b0, 1'b0);
    chain_case("m20pm20", -64'sd20, -64'sd20, 1'b0, -64'sd40, 1'b1, 1'b0);
    chain_case("maxp1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
  endtask

  initial begin
    test_truth_table();
    test_timing();
    test_reset();
    test_pipeline();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
